ram_lsu_master: RTL and testbench
=================================

// Module: ram_lsu_master
// PURPOSE
//  Initiator side of the single-port word RAM: converts RV32 load/store requests (byte/half/word,
//  signed/unsigned) into RAM accesses. The RAM has no byte enables, so sub-word stores are
//  done as read-modify-write. Sits between the core's memory stage and the data RAM instance.
// PARAMETERS
//  RAM_DEPTH  1024  RAM words; ADDR_W = $clog2(RAM_DEPTH) (localparam)
//  BASE_ADDR  32'h0 byte address mapped to RAM word 0
//  READ_LAT   0     RAM read latency in cycles: 0 = LOW_LATENCY RAM, 2 = HIGH_PERFORMANCE RAM
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  req_valid  in   1       request valid
//  req_ready  out  1       request accepted when valid&&ready
//  req_we     in   1       1 = store, 0 = load
//  req_size   in   2       00 byte, 01 half, 10 word, 11 = error
//  req_unsigned in 1       loads: zero-extend (1) / sign-extend (0)
//  req_addr   in   32      byte address
//  req_wdata  in   32      store data, right-aligned
//  rsp_valid  out  1       one-cycle completion pulse, no backpressure
//  rsp_rdata  out  32      load result (0 for stores/errors)
//  rsp_err    out  1       misaligned/out-of-range/bad size; valid with rsp_valid
//  ram_addr   out  ADDR_W  RAM word address (registered)
//  ram_din    out  32      RAM write data (registered)
//  ram_we     out  1       RAM write enable
//  ram_regce  out  1       RAM output register enable
//  ram_dout   in   32      RAM read data
// BEHAVIOUR
//  - Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_addr=0, ram_din=0,
//    ram_we=0, ram_regce=0. req_ready = (state==IDLE)&&!rst.
//  - ram_we = (state==WR)&&!rst, so no RAM write commits on an edge where rst is high.
//  - States: IDLE, RD, WR, RESP. Request fields are latched on accept.
//  - IDLE: accept. Check off = req_addr-BASE_ADDR. Error if size==11, half with addr[0]!=0,
//    word with addr[1:0]!=0, or off>=RAM_DEPTH*4. On error: ->RESP, no RAM access.
//    Otherwise: word store ->WR; load or sub-word store ->RD.
//  - RD: ram_addr=off[ADDR_W+1:2], ram_we=0, ram_regce=1. Counter runs 0..READ_LAT;
//    ram_dout is captured on the edge where cnt==READ_LAT. Load ->RESP; sub-word store ->WR.
//  - WR: ram_we=1 for exactly 1 cycle. ram_din is either the merged word (sub-word) or
//    req_wdata (word) ->RESP.
//  - RESP: rsp_valid=1 for 1 cycle ->IDLE.
//  - Lanes are little-endian: byte lane = off[1:0], half lane = off[1].
//  - Load extract: shift the selected lane to bit 0; bit 7/15 sign-extends unless req_unsigned.
//  - Merge: replace only the addressed lane in the captured word with req_wdata[7:0]/[15:0].
//    Other lanes are unchanged.
//  - Latency, accept in cycle T:
//    - error: rsp_valid in T+1
//    - word store: ram_we in T+1, rsp in T+2
//    - load: RD over T+1..T+1+READ_LAT, rsp in T+2+READ_LAT
//    - sub-word store: WR in T+2+READ_LAT, rsp in T+3+READ_LAT
//  - Back-to-back: the next request can be accepted in the cycle after RESP (IDLE).
//  - Reset mid-operation: the transaction is abandoned with no response, and any write not
//    yet committed is dropped.
//  - The top word (off = RAM_DEPTH*4-4) is legal; off = RAM_DEPTH*4 is an error (no wrap).
// TESTING
//  1 Word store 0xDEADBEEF @0x10, then word load @0x10 -> we pulse 1 cycle addr 4;
//    rsp_rdata=0xDEADBEEF, err=0.
//  2 Byte store 0x5A @0x13 over 0x11223344, then load word -> 0x5A223344;
//    exactly 1 read and 1 write observed.
//  3 Byte/half loads of 0x80F08001: lb @0x0 -> 0x00000001; lb @0x3 -> 0xFFFFFF80;
//    lbu @0x3 -> 0x80; lh @0x2 -> 0xFFFF80F0; lhu @0x2 -> 0x80F0.
//  4 Errors: lh @0x1, lw @0x2, size=11, lw @RAM_DEPTH*4 -> rsp_err=1 at T+1, ram_we never high.
//  5 Reset asserted during RD of a sub-word store -> no write, no rsp_valid;
//    memory unchanged; req_ready=1 after reset.
//  6 Repeat tests 1-3 with READ_LAT=2 against the HIGH_PERFORMANCE RAM ->
//    same data, load rsp at T+4.

Source files
------------

// File: rtl/ram_lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_lsu_master
// Purpose  : Initiator between the core memory stage and a single-port word
//            RAM without byte enables. Turns RV32 byte/half/word loads and
//            stores into RAM accesses. Sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module ram_lsu_master #(
   parameter int          RAM_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          READ_LAT  = 0,
   localparam int         ADDR_W    = $clog2(RAM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   output logic              ram_regce,
   input  logic [31:0]       ram_dout
);

   localparam int               CNT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(READ_LAT);
   localparam logic [32:0]      LIMIT = 33'(RAM_DEPTH) << 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         lane_q, lane_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
   logic [31:0]        ram_din_q, ram_din_d;

   logic [31:0]        w_off;
   logic               w_err;
   logic               w_accept;
   logic [4:0]         w_shamt;
   logic [31:0]        w_shifted;
   logic [31:0]        w_load;
   logic [31:0]        w_mask;
   logic [31:0]        w_merged;

   // Request decode: RAM-relative offset, alignment and range checks.
   assign w_off    = req_addr - BASE_ADDR;
   assign w_err    = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && w_off[0]) ||
                     ((req_size == 2'b10) && (w_off[1:0] != 2'b00)) ||
                     ({1'b0, w_off} >= LIMIT);
   assign w_accept = req_valid && req_ready;

   // Little-endian lane handling; for halves lane_q[0] is always 0.
   assign w_shamt   = {lane_q, 3'b000};
   assign w_shifted = ram_dout >> w_shamt;
   assign w_mask    = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
   assign w_merged  = (ram_dout & ~w_mask) | ((wdata_q << w_shamt) & w_mask);

   // Load extract with sign or zero extension.
   always_comb begin
      w_load = ram_dout;
      case (size_q)
         2'b00:   w_load = uns_q ? {24'h0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load = uns_q ? {16'h0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load = ram_dout;
      endcase
   end

   // Next-state and datapath next values.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               we_d       = req_we;
               size_d     = req_size;
               uns_d      = req_unsigned;
               lane_d     = w_off[1:0];
               wdata_d    = req_wdata;
               rdata_d    = 32'h0;
               err_d      = w_err;
               cnt_d      = '0;
               ram_addr_d = w_off[ADDR_W+1:2];
               if (w_err) begin
                  state_d = S_RESP;
               end else if (req_we && (req_size == 2'b10)) begin
                  ram_din_d = req_wdata;
                  state_d   = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            // RAM data is valid in the cycle where the counter reaches READ_LAT.
            if (cnt_q == LAT_C) begin
               if (we_q) begin
                  ram_din_d = w_merged;
                  state_d   = S_WR;
               end else begin
                  rdata_d = w_load;
                  state_d = S_RESP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WR:    state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   // Strobes are gated with rst so nothing reaches the RAM on a reset edge.
   assign req_ready = (state_q == S_IDLE) && !rst;
   assign ram_we    = (state_q == S_WR) && !rst;
   assign ram_regce = (state_q == S_RD) && !rst;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_lsu_master
// Purpose  : Directed bench for ram_lsu_master with a LOW_LATENCY (READ_LAT=0)
//            and a HIGH_PERFORMANCE (READ_LAT=2) RAM driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_lsu_master;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 24;

   logic        clk;
   logic        rst;
   logic        req_valid, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        rdy_a, rv_a, err_a, we_a, ce_a;
   logic [31:0] rd_a, din_a, dout_a;
   logic [9:0]  addr_a;
   logic        rdy_b, rv_b, err_b, we_b, ce_b;
   logic [31:0] rd_b, din_b, dout_b;
   logic [9:0]  addr_b;

   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] stage_b;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   int rsp_tot_a = 0, we_tot_a = 0, rd_tot_a = 0, rsp_cyc_a = -1;
   int rsp_tot_b = 0, we_tot_b = 0, rd_tot_b = 0, rsp_cyc_b = -1;
   logic [31:0] rsp_dat_a, rsp_dat_b;
   logic        rsp_err_a, rsp_err_b, ce_prev_a, ce_prev_b;
   logic [9:0]  we_adr_a, we_adr_b;

   vec_t tbl [NV];

   ram_lsu_master #(.RAM_DEPTH(1024), .BASE_ADDR(32'h0), .READ_LAT(0)) dut_a (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a),
      .rsp_rdata(rd_a), .rsp_err(err_a), .ram_addr(addr_a), .ram_din(din_a),
      .ram_we(we_a), .ram_regce(ce_a), .ram_dout(dout_a)
   );

   ram_lsu_master #(.RAM_DEPTH(1024), .BASE_ADDR(32'h0), .READ_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b),
      .rsp_rdata(rd_b), .rsp_err(err_b), .ram_addr(addr_b), .ram_din(din_b),
      .ram_we(we_b), .ram_regce(ce_b), .ram_dout(dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // LOW_LATENCY RAM: asynchronous read of the registered address.
   assign dout_a = mem_a[addr_a];
   always @(posedge clk) if (we_a) mem_a[addr_a] <= din_a;

   // HIGH_PERFORMANCE RAM: array register plus regce-enabled output register.
   always @(posedge clk) begin
      if (we_b) mem_b[addr_b] <= din_b;
      stage_b <= mem_b[addr_b];
      if (ce_b) dout_b <= stage_b;
   end

   // Cumulative activity monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (rv_a) begin rsp_tot_a++; rsp_cyc_a = cyc; rsp_dat_a = rd_a; rsp_err_a = err_a; end
      if (we_a) begin we_tot_a++; we_adr_a = addr_a; end
      if (ce_a && !ce_prev_a) rd_tot_a++;
      ce_prev_a = ce_a;
      if (rv_b) begin rsp_tot_b++; rsp_cyc_b = cyc; rsp_dat_b = rd_b; rsp_err_b = err_b; end
      if (we_b) begin we_tot_b++; we_adr_b = addr_b; end
      if (ce_b && !ce_prev_b) rd_tot_b++;
      ce_prev_b = ce_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input vec_t v, input int lat);
      if (v.exp_err) return 1;
      if (v.we && v.size == 2'b10) return 2;
      if (v.we) return 3 + lat;
      return 2 + lat;
   endfunction

   // Issue one request to both DUTs and check response, latency and RAM traffic.
   task automatic run_vec(input vec_t v, input string tag);
      int t0, sr_a, sw_a, sd_a, sr_b, sw_b, sd_b;
      int exp_we, exp_rd;
      @(negedge clk);
      t0 = cyc;
      sr_a = rsp_tot_a; sw_a = we_tot_a; sd_a = rd_tot_a;
      sr_b = rsp_tot_b; sw_b = we_tot_b; sd_b = rd_tot_b;
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      exp_we = (v.we && !v.exp_err) ? 1 : 0;
      exp_rd = (!v.exp_err && !(v.we && v.size == 2'b10)) ? 1 : 0;
      chk({tag, " A rsp count"}, rsp_tot_a - sr_a, 1);
      chk({tag, " A rdata"}, rsp_dat_a, v.exp_rdata);
      chk({tag, " A err"}, {31'h0, rsp_err_a}, {31'h0, v.exp_err});
      chk({tag, " A latency"}, rsp_cyc_a - t0, exp_lat(v, 0));
      chk({tag, " A writes"}, we_tot_a - sw_a, exp_we);
      chk({tag, " A reads"}, rd_tot_a - sd_a, exp_rd);
      chk({tag, " B rsp count"}, rsp_tot_b - sr_b, 1);
      chk({tag, " B rdata"}, rsp_dat_b, v.exp_rdata);
      chk({tag, " B err"}, {31'h0, rsp_err_b}, {31'h0, v.exp_err});
      chk({tag, " B latency"}, rsp_cyc_b - t0, exp_lat(v, 2));
      chk({tag, " B writes"}, we_tot_b - sw_b, exp_we);
      chk({tag, " B reads"}, rd_tot_b - sd_b, exp_rd);
      if (exp_we == 1) begin
         chk({tag, " A we addr"}, {22'h0, we_adr_a}, {22'h0, v.addr[11:2]});
         chk({tag, " B we addr"}, {22'h0, we_adr_b}, {22'h0, v.addr[11:2]});
      end
   endtask

   initial begin
      int sr_a, sw_a, sr_b, sw_b;
      vec_t v;

      for (int i = 0; i < 1024; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
      stage_b = 32'h0; dout_b = 32'h0;
      ce_prev_a = 1'b0; ce_prev_b = 1'b0;
      rsp_dat_a = 32'h0; rsp_dat_b = 32'h0; rsp_err_a = 1'b0; rsp_err_b = 1'b0;
      we_adr_a = '0; we_adr_b = '0;

      //             we    size   uns   addr          wdata          exp_rdata     err
      tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0};
      tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h5A22_3344, 1'b0};
      tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h80F0_8001, 32'h0000_0000, 1'b0};
      tbl[6]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001, 1'b0};
      tbl[7]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,         32'hFFFF_FF80, 1'b0};
      tbl[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0,         32'h0000_0080, 1'b0};
      tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,         32'hFFFF_80F0, 1'b0};
      tbl[10] = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         32'h0000_80F0, 1'b0};
      tbl[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,         32'h0000_0000, 1'b1};
      tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1};
      tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1};
      tbl[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
      tbl[15] = '{1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
      tbl[17] = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF, 32'h0000_0000, 1'b0};
      tbl[18] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_3344, 1'b0};
      tbl[19] = '{1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_8001, 1'b0};
      tbl[20] = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,         32'hFFFF_FF80, 1'b0};
      tbl[21] = '{1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h0000_0000, 1'b1};
      tbl[22] = '{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_0001, 32'h0000_0000, 1'b0};
      tbl[23] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'hBEEF_0144, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state, both instances.
      chk("reset A ready", {31'h0, rdy_a}, 32'h0);
      chk("reset A outs", {26'h0, rv_a, err_a, we_a, ce_a, 2'b00}, 32'h0);
      chk("reset A rdata", rd_a, 32'h0);
      chk("reset A addr", {22'h0, addr_a}, 32'h0);
      chk("reset A din", din_a, 32'h0);
      chk("reset B ready", {31'h0, rdy_b}, 32'h0);
      chk("reset B outs", {26'h0, rv_b, err_b, we_b, ce_b, 2'b00}, 32'h0);
      chk("reset B rdata", rd_b, 32'h0);
      chk("reset B addr", {22'h0, addr_b}, 32'h0);
      chk("reset B din", din_b, 32'h0);
      rst = 1'b0;
      #1;
      chk("post-reset A ready", {31'h0, rdy_a}, 32'h1);
      chk("post-reset B ready", {31'h0, rdy_b}, 32'h1);

      for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset while a sub-word store is in RD: no write, no response.
      @(negedge clk);
      sr_a = rsp_tot_a; sw_a = we_tot_a; sr_b = rsp_tot_b; sw_b = we_tot_b;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0000_0020; req_wdata = 32'h0000_0077;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rdreset A in RD", {31'h0, ce_a}, 32'h1);
      chk("rdreset B in RD", {31'h0, ce_b}, 32'h1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rdreset A ready", {31'h0, rdy_a}, 32'h1);
      chk("rdreset B ready", {31'h0, rdy_b}, 32'h1);
      repeat (6) @(negedge clk);
      #1;
      chk("rdreset A no rsp", rsp_tot_a - sr_a, 0);
      chk("rdreset A no write", we_tot_a - sw_a, 0);
      chk("rdreset B no rsp", rsp_tot_b - sr_b, 0);
      chk("rdreset B no write", we_tot_b - sw_b, 0);
      v = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'hBEEF_0144, 1'b0};
      run_vec(v, "rdreset readback");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
